// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the shared instruction/data memory port: fixed-latency
// transactions, data-first priority with a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [2:0]        dm_func,
    output logic              dm_ready,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_func,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic       OWN_FETCH  = 1'b0;

    state_t            state_q;
    logic              owner_q;
    logic [3:0]        lat_cnt_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic              grant_data_d;
    logic              any_req_s;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [2:0]        mem_func_q;
    logic              if_ready_q;
    logic              dm_ready_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       dm_rdata_q;

    assign any_req_s = if_req | dm_req;

    // Grant selection and starvation counter next-state
    always_comb begin
        grant_data_d = 1'b0;
        starve_d     = starve_q;
        if (dm_req && !(if_req && (starve_q == STARVE_LIM))) begin
            grant_data_d = 1'b1;
        end else begin
            grant_data_d = 1'b0;
        end
        if (!if_req) begin
            starve_d = 4'd0;
        end else if ((state_q == ST_IDLE) && any_req_s) begin
            if (!grant_data_d) begin
                starve_d = 4'd0;
            end else if (starve_q < STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Transaction FSM with registered memory-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_FETCH;
            lat_cnt_q   <= 4'd0;
            starve_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_func_q  <= 3'd0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
        end else begin
            starve_q   <= starve_d;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_q  <= grant_data_d;
                        mem_en_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                        if (grant_data_d) begin
                            mem_we_q    <= dm_we;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                            mem_func_q  <= dm_func;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= 32'd0;
                            mem_func_q  <= 3'b010;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // mem_we_q still holds the captured direction during ISSUE
                    if (mem_we_q) begin
                        dm_ready_q <= owner_q;
                        if_ready_q <= ~owner_q;
                        state_q    <= ST_RESP;
                    end else begin
                        lat_cnt_q <= LAT_LOAD;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_q == 4'd0) begin
                        if (owner_q == OWN_FETCH) begin
                            if_rdata_q <= mem_rdata;
                        end else begin
                            dm_rdata_q <= mem_rdata;
                        end
                        dm_ready_q <= owner_q;
                        if_ready_q <= ~owner_q;
                        state_q    <= ST_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_func  = mem_func_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall     = (dm_req & ~dm_ready_q) | (if_req & ~if_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level timing/arbitration
// model, behavioural memory, and a second instance for the MEM_LAT=1 corner.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        if_req, if_ready, dm_req, dm_we, dm_ready, mem_en, mem_we, stall;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  dm_func, mem_func;

    logic        l1_if_req, l1_if_ready, l1_dm_req, l1_dm_we, l1_dm_ready, l1_mem_en, l1_mem_we, l1_stall;
    logic [31:0] l1_if_addr, l1_if_rdata, l1_dm_addr, l1_dm_wdata, l1_dm_rdata;
    logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic [2:0]  l1_dm_func, l1_mem_func;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_func(dm_func), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_func(mem_func), .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ready(l1_if_ready), .if_rdata(l1_if_rdata),
        .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
        .dm_func(l1_dm_func), .dm_ready(l1_dm_ready), .dm_rdata(l1_dm_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_func(l1_mem_func), .mem_rdata(l1_mem_rdata), .stall(l1_stall)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural memory: word store plus a hash for never-written words
    logic [31:0] mem_store [bit [31:0]];
    int          rcyc     = 0;
    int          pend_cyc = -10;
    logic [31:0] pend_val = 32'h0;

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Read data is only correct during cycle (issue + MEM_LAT); inverted otherwise
    assign mem_rdata = (rcyc == pend_cyc) ? pend_val : ~pend_val;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                if (mem_we === 1'b1) mem_store[mem_addr] = mem_wdata;
                else begin
                    pend_val = mem_peek(mem_addr);
                    pend_cyc = rcyc + MEM_LAT + 1;
                end
            end
            rcyc++;
        end
    end

    typedef struct packed { logic st; logic [31:0] d; } exp_t;
    exp_t if_q[$];
    exp_t dm_q[$];
    bit   glog[$];
    int   if_lat, dm_lat;

    task automatic do_fetch(input logic [31:0] a);
        int n = 0;
        bit done = 1'b0;
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back('{st: 1'b0, d: mem_peek(a)});
        while (!done && n <= 200) begin
            @(negedge clk);
            if (if_ready === 1'b1) done = 1'b1;
            else n++;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL fetch_timeout: got no if_ready, expected one within 200 cycles");
        end
        if_lat = n;
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f);
        int n = 0;
        bit done = 1'b0;
        dm_we = we; dm_addr = a; dm_wdata = wd; dm_func = f;
        dm_req = 1'b1;
        dm_q.push_back('{st: we, d: mem_peek(a)});
        while (!done && n <= 200) begin
            @(negedge clk);
            if (dm_ready === 1'b1) done = 1'b1;
            else n++;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL data_timeout: got no dm_ready, expected one within 200 cycles");
        end
        dm_lat = n;
        @(posedge clk); #1;
        dm_req = 1'b0;
    endtask

    // Transaction-level model: arbiter free/busy, grant winner, ready cycle
    bit          mon_on = 1'b0;
    int          mcyc = 0, m_ready_at = -1, data_run = 0;
    bit          m_idle = 1'b1, m_own_data = 1'b0, fw;
    bit          e_en = 1'b0, e_ifr = 1'b0, e_dmr = 1'b0, e_dchk = 1'b0;
    bit          n_en, n_ifr, n_dmr;
    logic        e_we = 1'b0;
    logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
    logic [2:0]  e_func = 3'h0;
    logic [31:0] if_hold = 32'h0, dm_hold = 32'h0;
    exp_t        pe;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk1("mem_en", mem_en, e_en);
                if (e_en) begin
                    chk("mem_addr", mem_addr, e_addr);
                    chk1("mem_we", mem_we, e_we);
                    chk("mem_func", {29'd0, mem_func}, {29'd0, e_func});
                    if (e_dchk) chk("mem_wdata", mem_wdata, e_wdata);
                end
                chk1("if_ready", if_ready, e_ifr);
                chk1("dm_ready", dm_ready, e_dmr);
                chk1("stall", stall, (dm_req & ~e_dmr) | (if_req & ~e_ifr));
                if (if_ready === 1'b1) begin
                    if (if_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL if_unexpected: got if_ready with empty scoreboard");
                    end else begin
                        pe = if_q.pop_front();
                        if_hold = pe.d;
                    end
                end
                chk("if_rdata", if_rdata, if_hold);
                if (dm_ready === 1'b1) begin
                    if (dm_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL dm_unexpected: got dm_ready with empty scoreboard");
                    end else begin
                        pe = dm_q.pop_front();
                        if (!pe.st) dm_hold = pe.d;
                    end
                end
                chk("dm_rdata", dm_rdata, dm_hold);
                if (mem_en === 1'b1) glog.push_back(mem_addr >= 32'h2000);

                n_en = 1'b0; n_ifr = 1'b0; n_dmr = 1'b0;
                if (!rst_n) begin
                    m_idle = 1'b1; data_run = 0; m_ready_at = -1;
                    if_hold = 32'h0; dm_hold = 32'h0;
                end else begin
                    if (!if_req) data_run = 0;
                    if (m_idle && (if_req || dm_req)) begin
                        fw = if_req && (!dm_req || data_run >= STARVE_MAX);
                        n_en = 1'b1;
                        m_idle = 1'b0;
                        if (fw) begin
                            data_run = 0;
                            e_addr = if_addr; e_we = 1'b0; e_func = 3'b010; e_dchk = 1'b0;
                            m_own_data = 1'b0;
                            m_ready_at = mcyc + 2 + MEM_LAT;
                        end else begin
                            if (if_req && data_run < STARVE_MAX) data_run++;
                            e_addr = dm_addr; e_we = dm_we; e_wdata = dm_wdata; e_func = dm_func;
                            e_dchk = 1'b1;
                            m_own_data = 1'b1;
                            m_ready_at = mcyc + (dm_we ? 2 : 2 + MEM_LAT);
                        end
                    end else if (!m_idle) begin
                        if (mcyc + 1 == m_ready_at) begin
                            n_ifr = !m_own_data;
                            n_dmr = m_own_data;
                        end
                        if (mcyc == m_ready_at) m_idle = 1'b1;
                    end
                end
                e_en = n_en; e_ifr = n_ifr; e_dmr = n_dmr;
                mcyc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_func = 3'h0;
        l1_if_req = 1'b0; l1_if_addr = 32'h0; l1_dm_req = 1'b0; l1_dm_we = 1'b0;
        l1_dm_addr = 32'h0; l1_dm_wdata = 32'h0; l1_dm_func = 3'h0; l1_mem_rdata = 32'h0;
        mem_store[32'h100] = 32'h0050_0093;

        @(posedge clk);
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        chk("reset_mem_func", {29'd0, mem_func}, 32'h0);

        do_fetch(32'h100);
        chk("single_fetch_latency", if_lat, 2 + MEM_LAT);
        chk("single_fetch_data", if_rdata, 32'h0050_0093);

        fork
            do_fetch(32'h204);
            do_data(1'b0, 32'h2010, 32'h0, 3'b010);
        join
        chk("simul_data_latency", dm_lat, 2 + MEM_LAT);
        chk("simul_fetch_latency", if_lat, (MEM_LAT + 3) + (2 + MEM_LAT));

        do_data(1'b1, 32'h2000, 32'hDEAD_BEEF, 3'b010);
        chk("store_latency", dm_lat, 2);
        do_data(1'b0, 32'h2000, 32'h0, 3'b010);
        chk("store_readback", dm_rdata, 32'hDEAD_BEEF);

        glog.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) do_data(1'b0, 32'h2040 + 32'(i * 4), 32'h0, 3'b010);
            end
            do_fetch(32'h300);
        join
        chk("starve_grants", glog.size(), 7);
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk1("starve_order", glog[i], i != STARVE_MAX);

        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    do_fetch({20'd0, 10'($urandom_range(0, 1023)), 2'b00});
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    do_data(1'($urandom_range(0, 1)), 32'h2000 + 32'($urandom_range(0, 63) * 4),
                            $urandom, 3'($urandom_range(0, 7)));
                end
            end
        join

        if_addr = 32'h104; if_req = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        do_fetch(32'h108);
        chk("post_reset_fetch_latency", if_lat, 2 + MEM_LAT);

        l1_dm_addr = 32'h3000; l1_dm_func = 3'b010;
        for (int c = 0; c < 6; c++) begin
            l1_dm_req = (c <= 3);
            l1_mem_rdata = (c == 2) ? 32'hCAFE_F00D : 32'h0BAD_BAD0;
            @(negedge clk);
            chk1("lat1_mem_en", l1_mem_en, c == 1);
            chk1("lat1_dm_ready", l1_dm_ready, c == 3);
            if (c == 3) chk("lat1_dm_rdata", l1_dm_rdata, 32'hCAFE_F00D);
            @(posedge clk); #1;
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
